ca_fitness_evaluator: RTL and testbench
=======================================

Name: ca_fitness_evaluator

Overview:
- Downstream consumer of the binary cellular automaton's `state` bus; also drives its `ce`/load controls.
- Runs one evaluation episode: loads the seed, then steps the automaton until a stop condition.
- Stop conditions: fixed point, period-2 oscillation, or generation limit.
- On stop, scores the final grid against a target pattern and returns fitness through a valid/ready handshake.
- Feeds the genetic search loop (one evaluation per candidate rule/seed).

Parameters:
- Width, 8, grid columns (must match the automaton).
- Height, 8, grid rows (must match the automaton).
- GenWidth, 16, width of generation counter and `max_gen`.
- ScoreWidth, 16, width of fitness output (must be at least clog2(Width*Height+1)).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin an episode; ignored unless idle.
- max_gen  in  GenWidth  generation limit; sampled at start.
- target  in  Width*Height  target pattern; sampled at start.
- state  in  Width*Height  automaton grid output, bit index = row*Width+col.
- ca_load  out  1  active-high, one cycle; drives automaton reset so it loads its `set` seed.
- ca_ce  out  1  automaton clock enable.
- busy  out  1  high from the cycle after accepted start until return to IDLE.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts result.
- fitness  out  ScoreWidth  count of cells where final state equals target.
- generations  out  GenWidth  generations executed before stop.
- period  out  2  0 = limit reached, 1 = fixed point, 2 = period-2 oscillator.

Behaviour:
- Reset (rst=0, async): FSM=IDLE.
- All outputs 0 on reset; internal prev/prev2/counters cleared.
- FSM states: IDLE, LOAD, RUN, SCORE, DONE.
- IDLE: start=1 latches max_gen and target, then go to LOAD.
- LOAD (1 cycle): ca_load=1, ca_ce=0.
  - Clear gen_count, prev_valid, prev2_valid.
  - Go to RUN; in the first RUN cycle `state` is the seed (generation 0).
- RUN, each cycle, with g = gen_count and `state` = generation g:
  - stop1 = prev_valid && state==prev.
  - stop2 = !stop1 && prev2_valid && state==prev2.
  - stopL = !stop1 && !stop2 && g==max_gen.
  - stop = stop1 | stop2 | stopL.
  - ca_ce = !stop (combinational, RUN only); the grid freezes on the stop cycle.
  - If !stop: prev<=state, prev2<=prev, prev_valid<=1, prev2_valid<=prev_valid, gen_count<=g+1.
  - If stop: generations<=g, period<=1/2/0 per stop1/stop2/stopL, capture final grid into an internal register, go to SCORE.
- max_gen=0: stopL fires in the first RUN cycle; zero ca_ce pulses; generations=0.
- The stop-condition priority above (fixed point over period-2 over limit) holds even when several are true at once.
- gen_count never wraps, because stopL fires at max_gen ≤ 2^GenWidth-1.
- SCORE: serial, one row per cycle, exactly Height cycles.
  - acc += popcount(~(final_row ^ target_row)), row 0 first.
  - acc clears on SCORE entry.
  - After the last row: fitness<=acc, go to DONE.
- DONE: result_valid=1.
  - fitness/generations/period stable while result_valid=1 && result_ready=0.
  - Handshake completes on result_valid && result_ready at a rising edge: next cycle result_valid=0, busy=0, FSM=IDLE.
  - fitness/generations/period hold their last values until the next start.
- ca_ce=0 and ca_load=0 in IDLE, SCORE and DONE.
- start asserted outside IDLE is dropped, not queued.
- Reset mid-episode: everything returns to reset values immediately; no result is emitted.
- Episode latency from start: 1 (LOAD) + (generations+1) RUN cycles + Height SCORE cycles, then DONE.

Test Plan:
- Bench uses a scripted state source (grid sequence per ca_ce pulse, reloaded on ca_load); one smoke run uses the real automaton with survive=0, rise=0.
- Seed=target=64'hA5A5_0F0F_3C3C_FFFF, max_gen=0 -> zero ca_ce pulses, generations=0, period=0, fitness=64, result_valid exactly 1+1+8 cycles after start.
- Script gen0=X, gen1=Y, gen2=Y (X≠Y), max_gen=100, target=Y -> stop at g=2, ca_ce high exactly 2 cycles, period=1, generations=2, fitness=64.
- Script X,Y,X (blinker), target=~X -> period=2, generations=2, fitness=0.
- Script all-distinct grids, max_gen=10, target with 40 matching cells -> period=0, generations=10, fitness=40, exactly 10 ca_ce pulses.
- Hold result_ready=0 for 5 cycles and pulse start during DONE -> outputs unchanged, start ignored; ready=1 -> IDLE and busy=0 next cycle.
- Assert rst=0 during RUN at g=3 -> all outputs 0 asynchronously, no result_valid; new start afterwards runs a clean episode.
- Real automaton smoke run: rules survive=0, rise=0, random seed -> period=1, generations=2 (extinct at gen1), fitness = zeros in target.

Source files
------------

// File: rtl/ca_fitness_evaluator.sv
// rtl/ca_fitness_evaluator.sv - cellular automaton episode runner and fitness scorer
// Seeds the automaton, steps it to a fixed point, 2-cycle or generation limit, then scores one row per cycle.
module ca_fitness_evaluator #(
   parameter int Width      = 8,
   parameter int Height     = 8,
   parameter int GenWidth   = 16,
   parameter int ScoreWidth = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    start_i,
   input  logic [GenWidth-1:0]     max_gen_i,
   input  logic [Width*Height-1:0] target_i,
   input  logic [Width*Height-1:0] state_i,
   output logic                    ca_load_o,
   output logic                    ca_ce_o,
   output logic                    busy_o,
   output logic                    result_valid_o,
   input  logic                    result_ready_i,
   output logic [ScoreWidth-1:0]   fitness_o,
   output logic [GenWidth-1:0]     generations_o,
   output logic [1:0]              period_o
);
   localparam int Cells = Width * Height;
   localparam int RowW  = (Height > 1) ? $clog2(Height) : 1;

   typedef enum logic [2:0] {IDLE, LOAD, RUN, SCORE, DONE} state_e;

   state_e                fsm_q, fsm_d;
   logic [GenWidth-1:0]   max_gen_q, max_gen_d;
   logic [Cells-1:0]      target_q, target_d;
   logic [GenWidth-1:0]   gen_q, gen_d;
   logic [Cells-1:0]      prev_q, prev_d;
   logic [Cells-1:0]      prev2_q, prev2_d;
   logic                  pv_q, pv_d;
   logic                  p2v_q, p2v_d;
   logic [Cells-1:0]      final_q, final_d;
   logic [RowW-1:0]       row_q, row_d;
   logic [ScoreWidth-1:0] acc_q, acc_d;
   logic [ScoreWidth-1:0] fitness_q, fitness_d;
   logic [GenWidth-1:0]   generations_q, generations_d;
   logic [1:0]            period_q, period_d;

   logic                  stop1, stop2, stop_l, stop;
   logic [Width-1:0]      row_match;
   logic [ScoreWidth-1:0] row_pc;

   // Fixed point wins over period-2, which wins over the generation limit.
   assign stop1  = pv_q && (state_i == prev_q);
   assign stop2  = !stop1 && p2v_q && (state_i == prev2_q);
   assign stop_l = !stop1 && !stop2 && (gen_q == max_gen_q);
   assign stop   = stop1 | stop2 | stop_l;

   assign row_match = ~(final_q[row_q*Width +: Width] ^ target_q[row_q*Width +: Width]);

   always_comb begin
      row_pc = '0;
      for (int i = 0; i < Width; i++) begin
         row_pc = row_pc + ScoreWidth'(row_match[i]);
      end
   end

   always_comb begin
      fsm_d         = fsm_q;
      max_gen_d     = max_gen_q;
      target_d      = target_q;
      gen_d         = gen_q;
      prev_d        = prev_q;
      prev2_d       = prev2_q;
      pv_d          = pv_q;
      p2v_d         = p2v_q;
      final_d       = final_q;
      row_d         = row_q;
      acc_d         = acc_q;
      fitness_d     = fitness_q;
      generations_d = generations_q;
      period_d      = period_q;
      ca_load_o     = 1'b0;
      ca_ce_o       = 1'b0;
      case (fsm_q)
         IDLE: begin
            if (start_i) begin
               max_gen_d = max_gen_i;
               target_d  = target_i;
               fsm_d     = LOAD;
            end
         end
         LOAD: begin
            ca_load_o = 1'b1;
            gen_d     = '0;
            pv_d      = 1'b0;
            p2v_d     = 1'b0;
            fsm_d     = RUN;
         end
         RUN: begin
            if (stop) begin
               generations_d = gen_q;
               period_d      = stop1 ? 2'd1 : (stop2 ? 2'd2 : 2'd0);
               final_d       = state_i;
               acc_d         = '0;
               row_d         = '0;
               fsm_d         = SCORE;
            end else begin
               ca_ce_o = 1'b1;
               prev_d  = state_i;
               prev2_d = prev_q;
               pv_d    = 1'b1;
               p2v_d   = pv_q;
               gen_d   = gen_q + GenWidth'(1);
            end
         end
         SCORE: begin
            acc_d = acc_q + row_pc;
            row_d = row_q + RowW'(1);
            if (row_q == RowW'(Height - 1)) begin
               fitness_d = acc_q + row_pc;
               fsm_d     = DONE;
            end
         end
         DONE: begin
            if (result_ready_i) fsm_d = IDLE;
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fsm_q         <= IDLE;
         max_gen_q     <= '0;
         target_q      <= '0;
         gen_q         <= '0;
         prev_q        <= '0;
         prev2_q       <= '0;
         pv_q          <= 1'b0;
         p2v_q         <= 1'b0;
         final_q       <= '0;
         row_q         <= '0;
         acc_q         <= '0;
         fitness_q     <= '0;
         generations_q <= '0;
         period_q      <= '0;
      end else begin
         fsm_q         <= fsm_d;
         max_gen_q     <= max_gen_d;
         target_q      <= target_d;
         gen_q         <= gen_d;
         prev_q        <= prev_d;
         prev2_q       <= prev2_d;
         pv_q          <= pv_d;
         p2v_q         <= p2v_d;
         final_q       <= final_d;
         row_q         <= row_d;
         acc_q         <= acc_d;
         fitness_q     <= fitness_d;
         generations_q <= generations_d;
         period_q      <= period_d;
      end
   end

   assign busy_o         = (fsm_q != IDLE);
   assign result_valid_o = (fsm_q == DONE);
   assign fitness_o      = fitness_q;
   assign generations_o  = generations_q;
   assign period_o       = period_q;
endmodule

// File: tb/tb_ca_fitness_evaluator.sv
// tb/tb_ca_fitness_evaluator.sv - scripted-grid bench for ca_fitness_evaluator
module tb_ca_fitness_evaluator;
   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        start_i;
   logic [15:0] max_gen_i;
   logic [63:0] target_i;
   logic [63:0] state_i;
   logic        ca_load_o, ca_ce_o, busy_o, result_valid_o, result_ready_i;
   logic [15:0] fitness_o, generations_o;
   logic [1:0]  period_o;

   typedef struct {
      logic [15:0] fit;
      logic [15:0] gen;
      logic [1:0]  per;
      int          ce;
   } exp_t;
   exp_t sbq[$];

   logic [63:0] script [16];
   logic [3:0]  idx = '0;
   int          ce_count = 0;
   int          compared = 0;
   int          mismatched = 0;
   int          ce0;
   int          cyc;
   logic [63:0] x, y, seed, tgt;

   ca_fitness_evaluator dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .max_gen_i(max_gen_i),
      .target_i(target_i), .state_i(state_i), .ca_load_o(ca_load_o), .ca_ce_o(ca_ce_o),
      .busy_o(busy_o), .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
      .fitness_o(fitness_o), .generations_o(generations_o), .period_o(period_o)
   );

   always #5 clk_i = ~clk_i;

   // Scripted automaton: reload on ca_load, advance one grid per ca_ce pulse.
   assign state_i = script[idx];
   always @(posedge clk_i) begin
      if (ca_load_o) idx <= '0;
      else if (ca_ce_o && idx != 4'd15) idx <= idx + 4'd1;
   end
   always @(negedge clk_i) if (ca_ce_o) ce_count <= ce_count + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic begin_ep(input logic [15:0] mg, input logic [63:0] tg);
      @(negedge clk_i);
      max_gen_i = mg;
      target_i  = tg;
      start_i   = 1'b1;
      ce0       = ce_count;
      @(posedge clk_i);
      #1 start_i = 1'b0;
      chk("busy_after_start", busy_o, 1);
   endtask

   task automatic push_exp(input logic [15:0] f, input logic [15:0] g, input logic [1:0] p, input int c);
      exp_t e;
      e.fit = f; e.gen = g; e.per = p; e.ce = c;
      sbq.push_back(e);
   endtask

   task automatic wait_and_score(input string tag);
      exp_t e;
      cyc = 0;
      while (!result_valid_o && cyc < 200) begin
         @(posedge clk_i);
         #1 cyc++;
      end
      if (sbq.size() == 0) begin
         chk({tag, "_sb_empty"}, 1, 0);
      end else begin
         e = sbq.pop_front();
         chk({tag, "_valid"}, result_valid_o, 1);
         chk({tag, "_latency"}, cyc, 1 + (e.gen + 1) + 8);
         chk({tag, "_fitness"}, fitness_o, e.fit);
         chk({tag, "_generations"}, generations_o, e.gen);
         chk({tag, "_period"}, period_o, e.per);
         chk({tag, "_ce_pulses"}, ce_count - ce0, e.ce);
      end
   endtask

   task automatic ack(input string tag);
      @(negedge clk_i) result_ready_i = 1'b1;
      @(posedge clk_i);
      #1 result_ready_i = 1'b0;
      chk({tag, "_valid_drop"}, result_valid_o, 0);
      chk({tag, "_busy_drop"}, busy_o, 0);
   endtask

   initial begin
      rst_ni = 1'b0; start_i = 1'b0; max_gen_i = '0; target_i = '0; result_ready_i = 1'b0;
      for (int i = 0; i < 16; i++) script[i] = '0;
      #12;
      chk("rst_busy", busy_o, 0);
      chk("rst_valid", result_valid_o, 0);
      chk("rst_ce", ca_ce_o, 0);
      chk("rst_load", ca_load_o, 0);
      chk("rst_outs", {fitness_o, generations_o, period_o}, 0);
      @(negedge clk_i) rst_ni = 1'b1;

      // Generation limit of zero: stop on the seed itself.
      seed = 64'hA5A5_0F0F_3C3C_FFFF;
      for (int i = 0; i < 16; i++) script[i] = seed;
      push_exp(16'd64, 16'd0, 2'd0, 0);
      begin_ep(16'd0, seed);
      wait_and_score("maxgen0");
      ack("maxgen0");

      // Fixed point X,Y,Y.
      x = 64'h0123_4567_89AB_CDEF;
      y = 64'hFEDC_BA98_7654_3210;
      script[0] = x;
      for (int i = 1; i < 16; i++) script[i] = y;
      push_exp(16'd64, 16'd2, 2'd1, 2);
      begin_ep(16'd100, y);
      wait_and_score("fixed");
      ack("fixed");

      // Blinker X,Y,X; hold result and try to start again while DONE.
      for (int i = 0; i < 16; i++) script[i] = i[0] ? y : x;
      push_exp(16'd0, 16'd2, 2'd2, 2);
      begin_ep(16'd100, ~x);
      wait_and_score("blinker");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         start_i   = (i == 2);
         max_gen_i = 16'd7;
         @(posedge clk_i);
         #1;
         chk("hold_valid", result_valid_o, 1);
         chk("hold_outs", {fitness_o, generations_o, period_o}, {16'd0, 16'd2, 2'd2});
      end
      start_i = 1'b0;
      ack("blinker");
      @(posedge clk_i);
      #1 chk("start_dropped", busy_o, 0);

      // All distinct grids, limited at 10; 24 mismatching cells.
      for (int i = 0; i < 16; i++) script[i] = 64'hDEAD_BEEF_0000_0000 | 64'(i);
      push_exp(16'd40, 16'd10, 2'd0, 10);
      begin_ep(16'd10, script[10] ^ 64'h0000_0000_00FF_FFFF);
      wait_and_score("limit");
      ack("limit");

      // Asynchronous reset in RUN at g=3.
      begin_ep(16'd100, 64'h0);
      repeat (4) @(posedge clk_i);
      #1 chk("abort_ce_g3", ca_ce_o, 1);
      rst_ni = 1'b0;
      #1;
      chk("abort_busy", busy_o, 0);
      chk("abort_ce", ca_ce_o, 0);
      chk("abort_outs", {fitness_o, generations_o, period_o, result_valid_o}, 0);
      @(negedge clk_i) rst_ni = 1'b1;
      repeat (3) @(posedge clk_i);
      #1 chk("abort_no_result", result_valid_o, 0);

      // Clean episode after abort: automaton with survive=0, rise=0 dies at gen1.
      seed = {$urandom, $urandom} | 64'h1;
      tgt  = {$urandom, $urandom};
      script[0] = seed;
      for (int i = 1; i < 16; i++) script[i] = '0;
      push_exp(16'(64 - $countones(tgt)), 16'd2, 2'd1, 2);
      begin_ep(16'd100, tgt);
      wait_and_score("extinct");
      ack("extinct");

      chk("sb_drained", sbq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
